keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner. Drives the columns, samples the rows, debounces and latches presses into a sticky 16-bit key_data vector.
- Feeds the AHB-lite keyboard slave: key_data is the slave's read data, and key_clear is the slave's write-triggered clear pulse.
- Sits between the board keypad pins and the keyboard peripheral on the M0 bus.

Parameters:
- SCAN_DIV, 1000, HCLK cycles each column is driven (dwell). Legal range 4..65535.
- DEBOUNCE_CNT, 4, consecutive identical scan frames required before the stable state updates. Legal range 1..15.

Ports:
- HCLK  input  1  system clock.
- HRESET  input  1  synchronous, active-high reset.
- col_out  output  4  column drive, active-low, one-hot-low.
- row_in  input  4  row sense, active-low (pulled up; low = key pressed), asynchronous to HCLK.
- key_clear  input  1  clear strobe from the bus slave; high = clear all latched keys.
- key_data  output  16  sticky latched presses; bit index = col*4 + row.

Behaviour:
- Reset values: col_out=4'b1110, key_data=0, col_idx=0, dwell counter=0, frame/stable/debounce registers=0, FSM=DRIVE.
- row_in passes through a 2-flop synchronizer (row_sync); its reset value is 4'hF.
- FSM states:
  - DRIVE: col_out = ~(4'b0001 << col_idx); dwell counter counts 0..SCAN_DIV-1. At count SCAN_DIV-1 -> SAMPLE.
  - SAMPLE (1 cycle): raw_frame[col_idx*4 + r] <= ~row_sync[r] for r=0..3. Dwell counter clears. If col_idx==3 -> FRAME_END; else col_idx++ -> DRIVE.
  - FRAME_END (1 cycle): debounce evaluation; col_idx <= 0 -> DRIVE.
- Frame period = 4*(SCAN_DIV+1)+1 cycles. col_out changes only on entry to DRIVE.
- Debounce, in FRAME_END:
  - If raw_frame == prev_frame: stable_cnt saturates at DEBOUNCE_CNT-1; otherwise stable_cnt <= 0.
  - prev_frame <= raw_frame.
  - When raw_frame == prev_frame and stable_cnt == DEBOUNCE_CNT-1 (before increment), stable <= raw_frame.
  - DEBOUNCE_CNT=1: stable updates on the first repeat of a frame.
- Press edge: new_press = stable_next & ~stable, valid for the single cycle after stable updates (registered).
- key_data update, per cycle:
  - key_data <= (key_clear ? 16'h0 : key_data) | new_press.
  - When clear and a new press fall in the same cycle, the press wins: its bits are set.
  - Releases never clear key_data.
  - key_clear held high clears every cycle it is high.
  - A key held down is not re-latched after a clear until it is released and pressed again.
- Multiple simultaneous keys: all detected bits latch independently. No ghost filtering.
- Reset mid-scan: all state returns to reset values in the next cycle. No partial frame is kept.
- Latency: a press stable at the pins before a frame's column sample sets key_data within (DEBOUNCE_CNT+1) frames + 4 cycles.
- No combinational path from row_in or key_clear to col_out. key_data is a register output.

Optional Feature:
- Macro: KEYPAD_IRQ_EN.
- Defined:
  - Extra port key_irq, output, 1 bit, reset 0.
  - key_irq is high while key_data != 0, registered (same cycle key_data becomes nonzero or zero, +0 latency relative to key_data's register).
  - Also adds key_event, output, 1 bit: a one-cycle pulse concurrent with any nonzero new_press.
- Undefined: key_irq and key_event ports do not exist. Behaviour is otherwise identical.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_CNT=2, frame period 21 cycles):
- Reset -> col_out==4'b1110 and key_data==0. After release, col_out steps 1110 -> 1101 -> 1011 -> 0111, each held 5 cycles including SAMPLE, with a FRAME_END gap before wrapping to 1110.
- Model pulls row 2 low only while column 1 is driven, held 4 frames -> key_data==16'h0040 within 3 frames + 4 cycles and stays set after release.
- Row glitch lasting less than 1 frame on key (col 3, row 0) -> key_data stays 0.
- key_data==16'h0040, key_clear pulsed 1 cycle -> key_data==0 next cycle. Key still held -> remains 0. Release, re-press -> 16'h0040 again.
- Keys 0 and 15 pressed together (bits 0 and 15) -> key_data==16'h8001. key_clear asserted in the exact new_press cycle of a third key (bit 5) -> key_data==16'h0020.
- HRESET asserted mid-column-2 with key_data==16'h0001 -> next cycle key_data==0, col_out==4'b1110. With KEYPAD_IRQ_EN defined, key_irq tracks key_data!=0 and key_event pulses exactly once per latched press.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sync, frame debounce, sticky press latch.
// Define KEYPAD_IRQ_EN to add the key_irq level and key_event pulse outputs.
module keypad_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [3:0]  col_out,
  input  logic [3:0]  row_in,
  input  logic        key_clear,
  output logic [15:0] key_data
`ifdef KEYPAD_IRQ_EN
  ,
  output logic        key_irq,
  output logic        key_event
`endif
);

  typedef enum logic [1:0] {DRIVE, SAMPLE, FRAME_END} state_t;

  localparam logic [15:0] DWELL_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  STABLE_LAST = 4'(DEBOUNCE_CNT - 1);

  state_t      state, state_next;
  logic [15:0] dwell_cnt;
  logic [1:0]  col_idx;
  logic [3:0]  row_meta, row_sync;
  logic [15:0] raw_frame, prev_frame, stable, stable_next, new_press;
  logic [15:0] key_data_next;
  logic [3:0]  stable_cnt;
  logic        dwell_done, frame_same;

  assign dwell_done = (dwell_cnt == DWELL_LAST);
  assign frame_same = (raw_frame == prev_frame);

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= DRIVE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      DRIVE:     if (dwell_done) state_next = SAMPLE;
      SAMPLE:    state_next = (col_idx == 2'd3) ? FRAME_END : DRIVE;
      FRAME_END: state_next = DRIVE;
      default:   state_next = DRIVE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row_in;
      row_sync <= row_meta;
    end
  end

  // col_out is registered and only changes when the FSM enters DRIVE
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dwell_cnt <= '0;
      col_idx   <= '0;
      col_out   <= 4'b1110;
      raw_frame <= '0;
    end else begin
      case (state)
        DRIVE: dwell_cnt <= dwell_cnt + 16'd1;
        SAMPLE: begin
          dwell_cnt <= '0;
          raw_frame[{col_idx, 2'b00} +: 4] <= ~row_sync;
          if (col_idx != 2'd3) begin
            col_idx <= col_idx + 2'd1;
            col_out <= ~(4'b0001 << (col_idx + 2'd1));
          end
        end
        FRAME_END: begin
          col_idx <= '0;
          col_out <= 4'b1110;
        end
        default: dwell_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    stable_next = stable;
    if (state == FRAME_END && frame_same && stable_cnt == STABLE_LAST)
      stable_next = raw_frame;
  end

  // A press arriving with a clear in the same cycle survives the clear
  assign key_data_next = (key_clear ? 16'h0 : key_data) | new_press;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      prev_frame <= '0;
      stable_cnt <= '0;
      stable     <= '0;
      new_press  <= '0;
      key_data   <= '0;
    end else begin
      if (state == FRAME_END) begin
        prev_frame <= raw_frame;
        if (!frame_same)
          stable_cnt <= '0;
        else if (stable_cnt != STABLE_LAST)
          stable_cnt <= stable_cnt + 4'd1;
      end
      stable    <= stable_next;
      new_press <= stable_next & ~stable;
      key_data  <= key_data_next;
    end
  end

`ifdef KEYPAD_IRQ_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      key_irq   <= 1'b0;
      key_event <= 1'b0;
    end else begin
      key_irq   <= (key_data_next != 16'h0);
      key_event <= |(stable_next & ~stable);
    end
  end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan with a behavioural 4x4 key matrix.
// Build with KEYPAD_IRQ_EN defined to also check key_irq / key_event.
module tb_keypad_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 2;
  localparam int FRAME        = 4 * (SCAN_DIV + 1) + 1;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [3:0]  col_out;
  logic [3:0]  row_in;
  logic        key_clear = 1'b0;
  logic [15:0] key_data;
  logic [15:0] pressed = 16'h0;
`ifdef KEYPAD_IRQ_EN
  logic        key_irq;
  logic        key_event;
`endif

  int total = 0;
  int bad   = 0;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEBOUNCE_CNT)) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .col_out(col_out),
    .row_in(row_in),
    .key_clear(key_clear),
    .key_data(key_data)
`ifdef KEYPAD_IRQ_EN
    ,
    .key_irq(key_irq),
    .key_event(key_event)
`endif
  );

  always #5 HCLK = ~HCLK;

  // A pressed key pulls its row low only while its own column is driven low
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_out[c])
        for (int r = 0; r < 4; r++)
          if (pressed[c*4 + r]) row_in[r] = 1'b0;
  end

  task automatic apply_reset();
    HRESET    = 1'b1;
    pressed   = 16'h0;
    key_clear = 1'b0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    total++;
    if (col_out !== 4'b1110) begin
      bad++;
      $display("[TB] FAIL reset_col: got=%b expected=1110", col_out);
    end
    total++;
    if (key_data !== 16'h0) begin
      bad++;
      $display("[TB] FAIL reset_key: got=%h expected=0000", key_data);
    end
`ifdef KEYPAD_IRQ_EN
    total++;
    if (key_irq !== 1'b0 || key_event !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_irq: irq=%b event=%b expected=0/0", key_irq, key_event);
    end
`endif
    HRESET = 1'b0;
    for (int k = 1; k <= FRAME; k++) begin
      @(negedge HCLK);
      if (k < 5)         exp_col = 4'b1110;
      else if (k < 10)   exp_col = 4'b1101;
      else if (k < 15)   exp_col = 4'b1011;
      else if (k < FRAME) exp_col = 4'b0111;
      else               exp_col = 4'b1110;
      total++;
      if (col_out !== exp_col) begin
        bad++;
        $display("[TB] FAIL col_step%0d: got=%b expected=%b", k, col_out, exp_col);
      end
    end
  endtask

  task automatic test_press();
    bit found = 0;
    int events = 0;
    apply_reset();
    pressed[6] = 1'b1;
    for (int i = 0; i < 4*FRAME + 4; i++) begin
      @(negedge HCLK);
`ifdef KEYPAD_IRQ_EN
      if (key_event === 1'b1) events++;
      total++;
      if (key_irq !== (key_data != 16'h0)) begin
        bad++;
        $display("[TB] FAIL irq_track: irq=%b key_data=%h", key_irq, key_data);
      end
`endif
      if (key_data === 16'h0040) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL press_latency: got=%h expected=0040", key_data);
    end
    repeat (3*FRAME) begin
      @(negedge HCLK);
`ifdef KEYPAD_IRQ_EN
      if (key_event === 1'b1) events++;
`endif
    end
    pressed[6] = 1'b0;
    repeat (3*FRAME) begin
      @(negedge HCLK);
`ifdef KEYPAD_IRQ_EN
      if (key_event === 1'b1) events++;
`endif
    end
    total++;
    if (key_data !== 16'h0040) begin
      bad++;
      $display("[TB] FAIL press_sticky: got=%h expected=0040", key_data);
    end
`ifdef KEYPAD_IRQ_EN
    total++;
    if (events != 1) begin
      bad++;
      $display("[TB] FAIL event_count: got=%0d expected=1", events);
    end
`endif
  endtask

  task automatic test_glitch();
    bit found = 0;
    apply_reset();
    repeat (2*FRAME) @(negedge HCLK);
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge HCLK);
      if (col_out === 4'b0111) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL glitch_col3_wait: col=%b expected=0111", col_out);
    end
    pressed[12] = 1'b1;
    repeat (15) @(negedge HCLK);
    pressed[12] = 1'b0;
    repeat (5*FRAME) @(negedge HCLK);
    total++;
    if (key_data !== 16'h0) begin
      bad++;
      $display("[TB] FAIL glitch_reject: got=%h expected=0000", key_data);
    end
  endtask

  task automatic test_clear();
    bit found = 0;
    apply_reset();
    pressed[6] = 1'b1;
    for (int i = 0; i < 5*FRAME; i++) begin
      @(negedge HCLK);
      if (key_data === 16'h0040) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL clear_setup: got=%h expected=0040", key_data);
    end
    repeat (2) @(negedge HCLK);
    key_clear = 1'b1;
    @(negedge HCLK);
    key_clear = 1'b0;
    total++;
    if (key_data !== 16'h0) begin
      bad++;
      $display("[TB] FAIL clear_pulse: got=%h expected=0000", key_data);
    end
`ifdef KEYPAD_IRQ_EN
    total++;
    if (key_irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL clear_irq: got=%b expected=0", key_irq);
    end
`endif
    repeat (4*FRAME) @(negedge HCLK);
    total++;
    if (key_data !== 16'h0) begin
      bad++;
      $display("[TB] FAIL clear_held: got=%h expected=0000", key_data);
    end
    pressed[6] = 1'b0;
    repeat (5*FRAME) @(negedge HCLK);
    total++;
    if (key_data !== 16'h0) begin
      bad++;
      $display("[TB] FAIL clear_release: got=%h expected=0000", key_data);
    end
    pressed[6] = 1'b1;
    found = 0;
    for (int i = 0; i < 5*FRAME; i++) begin
      @(negedge HCLK);
      if (key_data === 16'h0040) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL clear_repress: got=%h expected=0040", key_data);
    end
    pressed[6] = 1'b0;
  endtask

  task automatic test_multi();
    bit found = 0;
    bit seen_last = 0;
    apply_reset();
    pressed = 16'h8001;
    for (int i = 0; i < 5*FRAME; i++) begin
      @(negedge HCLK);
      if (key_data === 16'h8001) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL multi_latch: got=%h expected=8001", key_data);
    end
    // Align to the first cycle of a frame (column 0 freshly driven)
    found = 0;
    for (int i = 0; i < 3*FRAME; i++) begin
      @(negedge HCLK);
      if (col_out === 4'b0111) seen_last = 1;
      else if (seen_last && col_out === 4'b1110) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL multi_align: col=%b expected=1110", col_out);
    end
    // Key 5 is sampled in this frame and becomes stable three frame ends later
    pressed[5] = 1'b1;
    repeat (3*FRAME) @(negedge HCLK);
    total++;
    if (key_data !== 16'h8001) begin
      bad++;
      $display("[TB] FAIL multi_before_clear: got=%h expected=8001", key_data);
    end
    key_clear = 1'b1;
    @(negedge HCLK);
    key_clear = 1'b0;
    total++;
    if (key_data !== 16'h0020) begin
      bad++;
      $display("[TB] FAIL clear_vs_press: got=%h expected=0020", key_data);
    end
    repeat (2*FRAME) @(negedge HCLK);
    total++;
    if (key_data !== 16'h0020) begin
      bad++;
      $display("[TB] FAIL multi_no_relatch: got=%h expected=0020", key_data);
    end
    pressed = 16'h0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    apply_reset();
    pressed[0] = 1'b1;
    for (int i = 0; i < 5*FRAME; i++) begin
      @(negedge HCLK);
      if (key_data === 16'h0001) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL midreset_setup: got=%h expected=0001", key_data);
    end
    found = 0;
    for (int i = 0; i < 2*FRAME; i++) begin
      @(negedge HCLK);
      if (col_out === 4'b1011) begin
        found = 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("[TB] FAIL midreset_col2: col=%b expected=1011", col_out);
    end
    @(negedge HCLK);
    HRESET = 1'b1;
    @(negedge HCLK);
    total++;
    if (key_data !== 16'h0) begin
      bad++;
      $display("[TB] FAIL midreset_key: got=%h expected=0000", key_data);
    end
    total++;
    if (col_out !== 4'b1110) begin
      bad++;
      $display("[TB] FAIL midreset_col: got=%b expected=1110", col_out);
    end
`ifdef KEYPAD_IRQ_EN
    total++;
    if (key_irq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset_irq: got=%b expected=0", key_irq);
    end
`endif
    HRESET  = 1'b0;
    pressed = 16'h0;
  endtask

  initial begin
    $display("[TB] keypad_scan bench start");
    test_reset();
    test_press();
    test_glitch();
    test_clear();
    test_multi();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
